// File: rtl/ahb_slave_port_mux.sv
// rtl/ahb_slave_port_mux.sv - routes the granted AHB master onto one slave port and steers data-phase responses back
// Optional burst protocol checker: define AHB_MUX_BURST_CHK_EN.
module ahb_slave_port_mux #(
   parameter int MASTER_NUM = 2,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
) (
   input  logic                         hclk,
   input  logic                         hreset_n,
   input  logic [MASTER_NUM-1:0]        hgrant,
   input  logic                         hsel,
   input  logic [MASTER_NUM*ADDR_W-1:0] m_haddr,
   input  logic [MASTER_NUM*2-1:0]      m_htrans,
   input  logic [MASTER_NUM-1:0]        m_hwrite,
   input  logic [MASTER_NUM*3-1:0]      m_hsize,
   input  logic [MASTER_NUM*3-1:0]      m_hburst,
   input  logic [MASTER_NUM*DATA_W-1:0] m_hwdata,
   output logic [DATA_W-1:0]            m_hrdata,
   output logic [MASTER_NUM-1:0]        m_hready,
   output logic [MASTER_NUM-1:0]        m_hresp,
   output logic                         s_hsel,
   output logic [ADDR_W-1:0]            s_haddr,
   output logic [1:0]                   s_htrans,
   output logic                         s_hwrite,
   output logic [2:0]                   s_hsize,
   output logic [2:0]                   s_hburst,
   output logic [DATA_W-1:0]            s_hwdata,
   input  logic [DATA_W-1:0]            s_hrdata,
   input  logic                         s_hreadyout,
   input  logic                         s_hresp,
   output logic                         hwait,
   output logic [2:0]                   hburst,
   output logic                         burst_err
);

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [MASTER_NUM-1:0] r_addr_owner;
   logic [MASTER_NUM-1:0] r_data_owner;
   logic [MASTER_NUM-1:0] w_grant_1h;
   logic [MASTER_NUM-1:0] w_addr_owner_nxt;
   logic [1:0]            w_htrans;
   logic                  w_bus_rdy;
   logic                  w_accept;

   // Illegal multi-hot grants resolve to the lowest index.
   always_comb begin
      w_grant_1h = '0;
      for (int i = MASTER_NUM - 1; i >= 0; i--) begin
         if (hgrant[i]) begin
            w_grant_1h    = '0;
            w_grant_1h[i] = 1'b1;
         end
      end
   end

   always_comb begin
      w_addr_owner_nxt = r_addr_owner;
      if (|hgrant)
         w_addr_owner_nxt = w_grant_1h;
      else if (!hsel)
         w_addr_owner_nxt = '0;
   end

   always_comb begin
      s_haddr  = '0;
      w_htrans = HTRANS_IDLE;
      s_hwrite = 1'b0;
      s_hsize  = '0;
      s_hburst = '0;
      s_hwdata = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (r_addr_owner[i]) begin
            s_haddr  = m_haddr[i*ADDR_W +: ADDR_W];
            w_htrans = m_htrans[i*2 +: 2];
            s_hwrite = m_hwrite[i];
            s_hsize  = m_hsize[i*3 +: 3];
            s_hburst = m_hburst[i*3 +: 3];
         end
         if (r_data_owner[i])
            s_hwdata = m_hwdata[i*DATA_W +: DATA_W];
      end
   end

   assign s_hsel    = hsel & (|r_addr_owner) & s_htrans[1];
   assign hburst    = s_hburst;
   assign m_hrdata  = s_hrdata;
   assign w_bus_rdy = (r_state == ST_IDLE) | s_hreadyout;
   assign w_accept  = s_hsel & w_bus_rdy;

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_state      <= ST_IDLE;
         r_addr_owner <= '0;
         r_data_owner <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr_owner <= w_addr_owner_nxt;
         if (w_accept)
            r_data_owner <= r_addr_owner;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_DATA;
         ST_DATA: begin
            if (s_hreadyout)
               w_state_nxt = w_accept ? ST_DATA : ST_IDLE;
            else if (s_hresp)
               w_state_nxt = ST_ERR;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Second ERROR cycle cancels whatever the owner has already queued.
   always_comb begin
      s_htrans = (r_state == ST_ERR) ? HTRANS_IDLE : w_htrans;
      hwait    = (r_state != ST_IDLE) & ~s_hreadyout;
      for (int i = 0; i < MASTER_NUM; i++) begin
         m_hready[i] = ((r_state != ST_IDLE) && (r_addr_owner[i] || r_data_owner[i]))
                       ? s_hreadyout : 1'b1;
         m_hresp[i]  = r_data_owner[i] & s_hresp;
      end
   end

`ifdef AHB_MUX_BURST_CHK_EN
   logic [3:0] r_left;
   logic [3:0] w_left_nxt;
   logic [3:0] w_len_m1;
   logic       r_fixed;
   logic       w_fixed_nxt;
   logic       r_burst_err;
   logic       w_slot;
   logic       w_seq;
   logic       w_ns;
   logic       w_idle;
   logic       w_err;

   assign w_slot = w_bus_rdy & (r_state != ST_ERR) & (|r_addr_owner);
   assign w_seq  = w_slot & (s_htrans == HTRANS_SEQ);
   assign w_ns   = w_slot & (s_htrans == HTRANS_NONSEQ);
   assign w_idle = w_slot & (s_htrans == HTRANS_IDLE);

   always_comb begin
      case (s_hburst[2:1])
         2'd1:    w_len_m1 = 4'd3;
         2'd2:    w_len_m1 = 4'd7;
         2'd3:    w_len_m1 = 4'd15;
         default: w_len_m1 = 4'd0;
      endcase
   end

   // r_left counts beats still owed after the current one.
   always_comb begin
      w_left_nxt  = r_left;
      w_fixed_nxt = r_fixed;
      if (r_state == ST_ERR) begin
         w_left_nxt  = '0;
         w_fixed_nxt = 1'b0;
      end else if (w_ns) begin
         w_left_nxt  = w_len_m1;
         w_fixed_nxt = (s_hburst[2:1] != 2'd0);
      end else if (w_seq && (r_left != 4'd0)) begin
         w_left_nxt  = r_left - 4'd1;
      end else if (w_idle) begin
         w_left_nxt  = '0;
      end
      w_err = (w_seq & r_fixed & (r_left == 4'd0))
            | ((w_ns | w_idle) & (r_left != 4'd0))
            | ((w_addr_owner_nxt != r_addr_owner) & (w_left_nxt != 4'd0));
      if (w_addr_owner_nxt != r_addr_owner) begin
         w_left_nxt  = '0;
         w_fixed_nxt = 1'b0;
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_left      <= '0;
         r_fixed     <= 1'b0;
         r_burst_err <= 1'b0;
      end else begin
         r_left      <= w_left_nxt;
         r_fixed     <= w_fixed_nxt;
         r_burst_err <= w_err;
      end
   end

   assign burst_err = r_burst_err;
`else
   assign burst_err = 1'b0;
`endif

endmodule
